// File: rtl/dma_pkg.sv
// Shared definitions for the DMA command queue: descriptor layout,
// opcodes and dispatcher states.
package dma_pkg;

    localparam int DMA_CMD_W = 128;

    localparam logic [7:0] DMA_OP_LOAD  = 8'h01;
    localparam logic [7:0] DMA_OP_STORE = 8'h02;

    localparam int OP_MSB   = 119;
    localparam int OP_LSB   = 112;
    localparam int EXT_MSB  = 111;
    localparam int EXT_LSB  = 72;
    localparam int SRAM_MSB = 71;
    localparam int SRAM_LSB = 52;
    localparam int ROWS_MSB = 51;
    localparam int ROWS_LSB = 40;
    localparam int COLS_MSB = 39;
    localparam int COLS_LSB = 28;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } dma_state_e;

    function automatic logic cmd_ok(
        input logic [7:0]  op,
        input logic [11:0] rows,
        input logic [11:0] cols
    );
        return ((op == DMA_OP_LOAD) || (op == DMA_OP_STORE))
            && (rows != '0) && (cols != '0);
    endfunction

endpackage

// File: rtl/dma_cmd_queue_if.sv
// Descriptor ingress and dma_engine issue handshakes of the
// command queue.
interface dma_cmd_queue_if;
    import dma_pkg::*;

    logic [DMA_CMD_W-1:0] in_cmd;
    logic                 in_valid;
    logic                 in_ready;
    logic [DMA_CMD_W-1:0] dma_cmd;
    logic                 dma_cmd_valid;
    logic                 dma_cmd_ready;
    logic                 dma_cmd_done;

    modport slave (
        input  in_cmd, in_valid, dma_cmd_ready, dma_cmd_done,
        output in_ready, dma_cmd, dma_cmd_valid
    );

    modport master (
        output in_cmd, in_valid, dma_cmd_ready, dma_cmd_done,
        input  in_ready, dma_cmd, dma_cmd_valid
    );

endinterface

// File: rtl/dma_cmd_fifo.sv
// Synchronous descriptor FIFO; pointers wrap modulo DEPTH and
// push/pop are ignored when full/empty.
module dma_cmd_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DMA_CMD_W-1:0]     din,
    input  logic                     pop,
    output logic [DMA_CMD_W-1:0]     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DMA_CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dma_cmd_queue.sv
// Validating command queue and in-order dispatcher for dma_engine.
// Optional WAIT watchdog enabled by defining DMA_CMD_TIMEOUT_EN.
module dma_cmd_queue
    import dma_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int DONE_CNT_W     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dma_cmd_queue_if.slave         cmd_if,
    input  logic                   fence_req,
    output logic                   fence_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] q_count,
    output logic [DONE_CNT_W-1:0]  done_count,
    output logic                   err_cmd,
    input  logic                   err_clr,
    output logic                   timeout_err
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
    begin : g_bad_param
        $error("dma_cmd_queue: illegal parameter value");
    end

    dma_state_e           state;
    dma_state_e           state_nxt;
    logic [DMA_CMD_W-1:0] head;
    logic                 full;
    logic                 empty;
    logic                 accept;
    logic                 cmd_good;
    logic                 push;
    logic                 pop;
    logic                 done_hit;
    logic                 timeout_hit;
    logic                 fence_seen;
    logic                 fence_hit;

    // in_ready is held low while in reset so nothing is accepted early
    assign cmd_if.in_ready = rst_n && !full && !fence_req;
    assign accept   = cmd_if.in_valid && cmd_if.in_ready;
    assign cmd_good = cmd_ok(cmd_if.in_cmd[OP_MSB:OP_LSB],
                             cmd_if.in_cmd[ROWS_MSB:ROWS_LSB],
                             cmd_if.in_cmd[COLS_MSB:COLS_LSB]);
    assign push     = accept && cmd_good;
    assign busy     = (q_count != '0) || (state != ST_IDLE);
    assign fence_hit = fence_req && !fence_seen
                    && (state == ST_IDLE) && empty;

    dma_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (cmd_if.in_cmd),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (q_count)
    );

`ifdef DMA_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;

    // wait_cnt holds 0 outside WAIT, so it restarts on every entry
    assign timeout_hit = (state == ST_WAIT) && !cmd_if.dma_cmd_done
                      && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + TW'(1) : '0;
            if (err_clr)          timeout_err <= 1'b0;
            else if (timeout_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        done_hit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_if.dma_cmd_valid && cmd_if.dma_cmd_ready)
                    state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (cmd_if.dma_cmd_done) begin
                    done_hit  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (timeout_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= ST_IDLE;
            cmd_if.dma_cmd       <= '0;
            cmd_if.dma_cmd_valid <= 1'b0;
            done_count           <= '0;
            err_cmd              <= 1'b0;
            fence_seen           <= 1'b0;
            fence_done           <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                cmd_if.dma_cmd       <= head;
                cmd_if.dma_cmd_valid <= 1'b1;
            end else if (state == ST_ISSUE && cmd_if.dma_cmd_ready) begin
                cmd_if.dma_cmd_valid <= 1'b0;
            end
            if (done_hit) done_count <= done_count + DONE_CNT_W'(1);
            if (err_clr)                 err_cmd <= 1'b0;
            else if (accept && !cmd_good) err_cmd <= 1'b1;
            fence_done <= fence_hit;
            fence_seen <= fence_req && (fence_seen || fence_hit);
        end
    end

endmodule

// File: tb/tb_dma_cmd_queue.sv
// Directed bench for dma_cmd_queue: validation table plus
// deep-queue, fence, push/pop, watchdog and reset sequences.
module tb_dma_cmd_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fence_req = 1'b0;
    logic        err_clr = 1'b0;
    logic        fence_done;
    logic        busy;
    logic        err_cmd;
    logic        timeout_err;
    logic [3:0]  q_count;
    logic [15:0] done_count;

    int checks = 0;
    int errors = 0;
    int exp_done = 0;
    int fence_pulses = 0;

    dma_cmd_queue_if bus ();

    dma_cmd_queue #(
        .DEPTH          (8),
        .DONE_CNT_W     (16),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_if      (bus),
        .fence_req   (fence_req),
        .fence_done  (fence_done),
        .busy        (busy),
        .q_count     (q_count),
        .done_count  (done_count),
        .err_cmd     (err_cmd),
        .err_clr     (err_clr),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (fence_done === 1'b1) fence_pulses++;

    typedef struct {
        logic [127:0] cmd;
        logic         good;
    } vec_t;

    vec_t vt [8];

    function automatic logic [127:0] mk(
        input logic [7:0]  op,
        input logic [39:0] ext,
        input logic [19:0] sram,
        input logic [11:0] rows,
        input logic [11:0] cols
    );
        logic [127:0] c;
        c = '0;
        c[119:112] = op;
        c[111:72]  = ext;
        c[71:52]   = sram;
        c[51:40]   = rows;
        c[39:28]   = cols;
        c[7:0]     = 8'h5a;
        return c;
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (bus.dma_cmd_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(name, bus.dma_cmd_valid, 1);
    endtask

    task automatic finish_cmd(input int gap);
        bus.dma_cmd_ready = 1'b1;
        tick();
        bus.dma_cmd_ready = 1'b0;
        repeat (gap) tick();
        bus.dma_cmd_done = 1'b1;
        tick();
        bus.dma_cmd_done = 1'b0;
        exp_done++;
    endtask

    task automatic push(input logic [127:0] c);
        bus.in_cmd   = c;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int p0;
        logic [39:0] ext;
        bus.in_cmd        = '0;
        bus.in_valid      = 1'b0;
        bus.dma_cmd_ready = 1'b0;
        bus.dma_cmd_done  = 1'b0;

        vt[0] = '{mk(8'h02, 40'h280, 20'h140, 12'd1, 12'd1), 1'b1};
        vt[1] = '{mk(8'h01, 40'h12345, 20'h40, 12'd4, 12'd8), 1'b1};
        vt[2] = '{mk(8'h07, 40'h100, 20'h10, 12'd1, 12'd1), 1'b0};
        vt[3] = '{mk(8'h01, 40'h200, 20'h20, 12'd0, 12'd3), 1'b0};
        vt[4] = '{mk(8'h02, 40'h300, 20'h30, 12'd3, 12'd0), 1'b0};
        vt[5] = '{mk(8'h00, 40'h400, 20'h40, 12'd1, 12'd1), 1'b0};
        vt[6] = '{mk(8'h03, 40'h500, 20'h50, 12'd2, 12'd2), 1'b0};
        vt[7] = '{mk(8'h01, 40'hff_ffff_ffff, 20'hfffff, 12'hfff, 12'hfff), 1'b1};

        // reset state
        tick();
        check("rst_valid", bus.dma_cmd_valid, 0);
        check("rst_dma_cmd", bus.dma_cmd, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_rel_in_ready", bus.in_ready, 1);
        check("rst_q_count", q_count, 0);
        check("rst_done_count", done_count, 0);
        check("rst_err", err_cmd, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_fence_done", fence_done, 0);

        // validation table
        for (int i = 0; i < 8; i++) begin
            bus.in_cmd   = vt[i].cmd;
            bus.in_valid = 1'b1;
            #1;
            check("tbl_in_ready", bus.in_ready, 1);
            tick();
            bus.in_valid = 1'b0;
            check("tbl_err_set", err_cmd, !vt[i].good);
            check("tbl_q_push", q_count, vt[i].good ? 1 : 0);
            check("tbl_valid_early", bus.dma_cmd_valid, 0);
            tick();
            check("tbl_issued", bus.dma_cmd_valid, vt[i].good);
            check("tbl_q_pop", q_count, 0);
            if (vt[i].good) begin
                check("tbl_dma_cmd", bus.dma_cmd, vt[i].cmd);
                finish_cmd(4);
                check("tbl_done_count", done_count, exp_done);
                check("tbl_busy", busy, 0);
            end else begin
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
                check("tbl_err_clr", err_cmd, 0);
            end
        end

        // clear wins over a same-cycle error
        err_clr = 1'b1;
        push(vt[2].cmd);
        err_clr = 1'b0;
        check("clr_wins", err_cmd, 0);
        check("clr_wins_q", q_count, 0);

        // nine descriptors into an 8-deep queue
        for (int i = 0; i < 9; i++) begin
            bus.in_cmd   = mk(8'h01, 40'h1000 + 40'(i * 256), 20'(i), 12'd2, 12'd3);
            bus.in_valid = 1'b1;
            #1;
            check("deep_in_ready", bus.in_ready, 1);
            tick();
        end
        bus.in_valid = 1'b0;
        check("deep_full_q", q_count, 8);
        check("deep_full_rdy", bus.in_ready, 0);
        check("deep_issue", bus.dma_cmd_valid, 1);
        bus.in_cmd   = mk(8'h01, 40'hdead, 20'h1, 12'd1, 12'd1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("deep_no_push_full", q_count, 8);
        for (int i = 0; i < 9; i++) begin
            wait_valid("deep_valid");
            ext = bus.dma_cmd[111:72];
            check("deep_order", ext, 40'h1000 + 40'(i * 256));
            finish_cmd(1);
        end
        check("deep_done_count", done_count, exp_done);
        check("deep_busy", busy, 0);

        // fence behind three queued commands
        p0 = fence_pulses;
        for (int i = 0; i < 3; i++)
            push(mk(8'h02, 40'h3000 + 40'(i), 20'h3, 12'd1, 12'd1));
        fence_req = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            wait_valid("fence_valid");
            check("fence_in_ready", bus.in_ready, 0);
            check("fence_early", fence_pulses - p0, 0);
            finish_cmd(1);
        end
        check("fence_at_done", fence_pulses - p0, 0);
        repeat (4) tick();
        check("fence_once", fence_pulses - p0, 1);
        check("fence_in_ready_hold", bus.in_ready, 0);
        fence_req = 1'b0;
        tick();
        check("fence_drop_rdy", bus.in_ready, 1);
        fence_req = 1'b1;
        repeat (3) tick();
        check("fence_repulse", fence_pulses - p0, 2);
        fence_req = 1'b0;
        tick();

        // push and pop together at q_count=4
        for (int i = 0; i < 5; i++)
            push(mk(8'h01, 40'h4000 + 40'(i), 20'h4, 12'd1, 12'd2));
        check("pp_q4", q_count, 4);
        check("pp_issue", bus.dma_cmd_valid, 1);
        bus.dma_cmd_done = 1'b1;
        tick();
        bus.dma_cmd_done = 1'b0;
        check("pp_done_in_issue", done_count, exp_done);
        check("pp_still_issue", bus.dma_cmd_valid, 1);
        finish_cmd(0);
        bus.in_cmd   = mk(8'h01, 40'h4005, 20'h4, 12'd1, 12'd2);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("pp_q_same", q_count, 4);
        check("pp_valid", bus.dma_cmd_valid, 1);
        for (int i = 1; i < 6; i++) begin
            wait_valid("pp_drain_valid");
            ext = bus.dma_cmd[111:72];
            check("pp_order", ext, 40'h4000 + 40'(i));
            finish_cmd(0);
        end
        check("pp_done_count", done_count, exp_done);

`ifdef DMA_CMD_TIMEOUT_EN
        push(mk(8'h02, 40'h5000, 20'h5, 12'd1, 12'd1));
        push(mk(8'h02, 40'h5001, 20'h5, 12'd1, 12'd1));
        check("to_issue", bus.dma_cmd_valid, 1);
        bus.dma_cmd_ready = 1'b1;
        tick();
        bus.dma_cmd_ready = 1'b0;
        repeat (15) tick();
        check("to_not_yet", timeout_err, 0);
        check("to_busy", busy, 1);
        tick();
        check("to_set", timeout_err, 1);
        check("to_no_done", done_count, exp_done);
        tick();
        check("to_next_valid", bus.dma_cmd_valid, 1);
        ext = bus.dma_cmd[111:72];
        check("to_next_cmd", ext, 40'h5001);
        finish_cmd(0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_clr", timeout_err, 0);
        check("to_done_count", done_count, exp_done);
`endif

        // async reset in the middle of WAIT
        push(mk(8'h01, 40'h6000, 20'h6, 12'd1, 12'd1));
        wait_valid("rw_valid");
        bus.dma_cmd_ready = 1'b1;
        tick();
        bus.dma_cmd_ready = 1'b0;
        push(mk(8'h01, 40'h6001, 20'h6, 12'd1, 12'd1));
        bus.in_valid = 1'b1;
        err_clr = 1'b0;
        bus.in_cmd = vt[2].cmd;
        tick();
        bus.in_valid = 1'b0;
        check("rw_busy", busy, 1);
        check("rw_err", err_cmd, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_valid_clr", bus.dma_cmd_valid, 0);
        check("rw_cmd_clr", bus.dma_cmd, 0);
        check("rw_busy_clr", busy, 0);
        check("rw_q_clr", q_count, 0);
        check("rw_done_clr", done_count, 0);
        check("rw_err_clr", err_cmd, 0);
        check("rw_in_ready", bus.in_ready, 0);
        tick();
        rst_n = 1'b1;
        exp_done = 0;
        bus.dma_cmd_done = 1'b1;
        tick();
        bus.dma_cmd_done = 1'b0;
        check("rw_done_ignored", done_count, 0);
        check("rw_in_ready_rel", bus.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_cmd_queue.md
Name: dma_cmd_queue

Overview:
- Command buffer and dispatcher directly upstream of dma_engine.
- Accepts 128-bit DMA descriptors from the control sequencer into a FIFO, validates them, and issues them one at a time to dma_engine over its cmd/cmd_valid/cmd_ready/cmd_done interface.
- Provides a fence for barrier synchronisation, plus completion and error status.

Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- DONE_CNT_W, 16: width of the completion counter.
- TIMEOUT_CYCLES, 4096: watchdog limit. Used only when DMA_CMD_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_cmd  in  128  descriptor. Fields: [119:112] opcode, [111:72] ext byte addr, [71:52] sram byte addr, [51:40] rows, [39:28] cols.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  queue can accept.
- dma_cmd  out  128  descriptor to dma_engine; registered.
- dma_cmd_valid  out  1  issue valid.
- dma_cmd_ready  in  1  dma_engine accepts.
- dma_cmd_done  in  1  single-cycle completion pulse from dma_engine.
- fence_req  in  1  level; request a barrier.
- fence_done  out  1  single-cycle pulse when the barrier is satisfied.
- busy  out  1  queue non-empty or a command is in flight.
- q_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- done_count  out  DONE_CNT_W  completed commands; wraps modulo 2^DONE_CNT_W.
- err_cmd  out  1  sticky; an invalid descriptor was dropped.
- err_clr  in  1  clears err_cmd and timeout_err.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, rst_n=0): FIFO empty; state IDLE; all outputs 0, except in_ready=1 once reset is released; dma_cmd=0.
- Reset mid-operation: the in-flight command is abandoned; no done is counted.
- in_ready = (q_count < DEPTH) && !fence_req.
- Enqueue on in_valid && in_ready.
- Validation at enqueue: opcode must be 8'h01 (LOAD) or 8'h02 (STORE), and rows != 0 and cols != 0.
  - An invalid descriptor still completes the handshake but is not written to the FIFO; err_cmd sets at that edge.
- Simultaneous push and pop: q_count unchanged; no corruption at full or empty. Pointers wrap modulo DEPTH.
- State machine IDLE / ISSUE / WAIT:
  - IDLE: if FIFO non-empty, register the head into dma_cmd, pop, set dma_cmd_valid=1, go to ISSUE. A descriptor enqueued at edge E into an empty queue in IDLE is popped at E+1, with dma_cmd_valid high after E+1.
  - ISSUE: hold dma_cmd and dma_cmd_valid stable until dma_cmd_valid && dma_cmd_ready. On that edge, clear valid and go to WAIT.
  - WAIT: on dma_cmd_done, increment done_count and go to IDLE. The next issue may occur at the following edge.
  - dma_cmd_done outside WAIT is ignored.
- Commands are strictly in order, with at most one outstanding.
- busy = (q_count != 0) || (state != IDLE).
- fence_done pulses for one cycle at the first edge where fence_req=1, state=IDLE and the FIFO is empty. It re-pulses only after fence_req drops and rises again.
- err_clr has priority over a same-cycle error set (clear wins).

Optional Feature:
- Macro: DMA_CMD_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT and resets on entry to WAIT.
  - On reaching TIMEOUT_CYCLES without dma_cmd_done: set timeout_err, go to IDLE, and do not increment done_count.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - timeout_err is tied to 0.

Decomposition:
- Package dma_pkg holds:
  - DMA_CMD_W=128;
  - DMA_OP_LOAD=8'h01 and DMA_OP_STORE=8'h02;
  - field MSB/LSB constants for opcode, ext addr, sram addr, rows and cols;
  - the FSM state enum.
- Sub-module dma_cmd_fifo: a synchronous FIFO with push, pop, full, empty and count. The dispatcher FSM and validation stay in dma_cmd_queue.

Test Plan:
- Single STORE (op 02, ext 0x280, sram 0x140, 1x1) into an empty queue, dma_cmd_ready=1:
  - dma_cmd_valid high one edge after enqueue, with dma_cmd equal to the input.
  - Done pulse 5 cycles later gives done_count=1 and busy=0.
- Push 9 descriptors with DEPTH=8 while dma_cmd_ready=0:
  - The first is popped to ISSUE, the next 8 fill the FIFO and in_ready=0 at q_count=8.
  - Releasing ready drains all 9 in order, verified by ext addr sequence, giving done_count=9.
- Descriptor with opcode 0x07, then one with rows=0:
  - Both are handshaked, neither is issued, err_cmd=1 and q_count=0.
  - err_clr returns err_cmd to 0.
- 3 commands queued, fence_req raised:
  - in_ready=0 throughout; fence_done pulses exactly once, only after the third dma_cmd_done.
- Push and pop in the same cycle at q_count=4:
  - q_count stays 4; done pulse injected in ISSUE is not counted.
- With DMA_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16, never pulse done:
  - timeout_err=1 at WAIT entry+16 and the next command issues.
  - Also: rst_n asserted mid-WAIT clears all outputs asynchronously.
